// File: rtl/onehot_decoder_3to8.sv
// Binary-to-one-hot decoder with enable, registered shadow and decode counter.
// Define DES_ONEHOT_CHECK_EN to add the sticky onehot_err output and assertions.
module onehot_decoder_3to8 #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] number,
  input  logic             en,
  output logic [OUT_W-1:0] Y,
  output logic [OUT_W-1:0] y_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] dec_count
`ifdef DES_ONEHOT_CHECK_EN
  ,
  output logic             onehot_err
`endif
);

  if (OUT_W != 2**SEL_W) begin : g_bad_width
    $error("OUT_W must equal 2**SEL_W");
  end

  // en is ANDed into every term so X on number cannot leak when disabled
  always_comb begin
    Y = '0;
    for (int i = 0; i < OUT_W; i++) begin
      Y[i] = en && (number == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      valid_q   <= 1'b0;
      dec_count <= '0;
    end else begin
      y_q     <= Y;
      valid_q <= en;
      if (en && (dec_count != {CNT_W{1'b1}})) begin
        dec_count <= dec_count + 1'b1;
      end
    end
  end

`ifdef DES_ONEHOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_err <= 1'b0;
    end else begin
      if ($countones(Y) != int'(en)) begin
        onehot_err <= 1'b1;
      end
      assert ($countones(Y) == int'(en));
      assert ($countones(y_q) == int'(valid_q));
    end
  end
`endif

endmodule

// File: tb/tb_onehot_decoder_3to8.sv
// Directed and random checks for onehot_decoder_3to8.
// A second instance with CNT_W=2 covers counter saturation.
module tb_onehot_decoder_3to8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  number;
  logic        en;
  logic [7:0]  Y;
  logic [7:0]  y_q;
  logic        valid_q;
  logic [15:0] dec_count;
  logic [7:0]  s_Y;
  logic [7:0]  s_y_q;
  logic        s_valid_q;
  logic [1:0]  s_dec_count;
`ifdef DES_ONEHOT_CHECK_EN
  logic        onehot_err;
  logic        s_onehot_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_3to8 u_dut (
    .clk       (clk),
    .rst       (rst),
    .number    (number),
    .en        (en),
    .Y         (Y),
    .y_q       (y_q),
    .valid_q   (valid_q),
    .dec_count (dec_count)
`ifdef DES_ONEHOT_CHECK_EN
    ,
    .onehot_err(onehot_err)
`endif
  );

  onehot_decoder_3to8 #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .number    (number),
    .en        (en),
    .Y         (s_Y),
    .y_q       (s_y_q),
    .valid_q   (s_valid_q),
    .dec_count (s_dec_count)
`ifdef DES_ONEHOT_CHECK_EN
    ,
    .onehot_err(s_onehot_err)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] terms(input logic [2:0] n,
                                       input logic e);
    logic [7:0] t;
    t[0] = e & ~n[2] & ~n[1] & ~n[0];
    t[1] = e & ~n[2] & ~n[1] &  n[0];
    t[2] = e & ~n[2] &  n[1] & ~n[0];
    t[3] = e & ~n[2] &  n[1] &  n[0];
    t[4] = e &  n[2] & ~n[1] & ~n[0];
    t[5] = e &  n[2] & ~n[1] &  n[0];
    t[6] = e &  n[2] &  n[1] & ~n[0];
    t[7] = e &  n[2] &  n[1] &  n[0];
    return t;
  endfunction

  logic [7:0] tt [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                         8'h10, 8'h20, 8'h40, 8'h80};
  int rmis;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    number = 3'd0;
    tick();
    tick();
    check("rst_y_q", 32'(y_q), 32'h0);
    check("rst_valid", 32'(valid_q), 32'h0);
    check("rst_cnt", 32'(dec_count), 32'h0);

    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      number = 3'(i);
      #1;
      check($sformatf("sweep_%0d", i), 32'(Y), 32'(tt[i]));
    end

    en = 1'b0;
    number = 3'd3;
    #1 check("dis_3", 32'(Y), 32'h0);
    number = 3'd7;
    #1 check("dis_7", 32'(Y), 32'h0);
    number = 3'bx;
    #1 check("dis_x", 32'(Y), 32'h0);

    rmis = 0;
    for (int i = 0; i < 10000; i++) begin
      number = 3'($urandom_range(7));
      en = 1'($urandom_range(1));
      #1;
      if (Y !== terms(number, en)) rmis++;
    end
    check("random_mis", 32'(rmis), 32'h0);

    tick();
    tick();
    rst = 1'b0;
    en = 1'b1;
    number = 3'd2;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("run_y_q_%0d", k), 32'(y_q), 32'h04);
      check($sformatf("run_vld_%0d", k), 32'(valid_q), 32'h1);
      check($sformatf("run_cnt_%0d", k), 32'(dec_count), 32'(k));
    end

    en = 1'b0;
    number = 3'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("idle_cnt_%0d", k), 32'(dec_count), 32'h3);
      check($sformatf("idle_vld_%0d", k), 32'(valid_q), 32'h0);
      check($sformatf("idle_y_q_%0d", k), 32'(y_q), 32'h0);
    end

    rst = 1'b1;
    en = 1'b1;
    number = 3'd2;
    tick();
    check("rst_en_y_q", 32'(y_q), 32'h0);
    check("rst_en_vld", 32'(valid_q), 32'h0);
    check("rst_en_cnt", 32'(dec_count), 32'h0);
    check("rst_en_Y", 32'(Y), 32'h04);

    rst = 1'b0;
    number = 3'd6;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("sat_cnt_%0d", k), 32'(s_dec_count),
            32'((k > 3) ? 3 : k));
      check($sformatf("big_cnt_%0d", k), 32'(dec_count), 32'(k));
`ifdef DES_ONEHOT_CHECK_EN
      check($sformatf("err_%0d", k), 32'(onehot_err), 32'h0);
      check($sformatf("s_err_%0d", k), 32'(s_onehot_err), 32'h0);
`endif
    end
    check("sat_y_q", 32'(s_y_q), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
